// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Digit width and the add-3 adjustment constants live here so both files agree.
package bcd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int                     BCD_DIGIT_W    = 4;
  localparam logic [BCD_DIGIT_W-1:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [BCD_DIGIT_W-1:0] BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 so that the
// following left shift carries into the next decimal digit.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [BCD_DIGIT_W-1:0] o_digit
);

  // NOTE: a continuous assign with both arms of the ternary covered cannot infer a latch.
  assign o_digit = (i_digit >= BCD_ADJ_THRESH) ? i_digit + BCD_ADJ_ADD : i_digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one shift-and-add-3 step per input bit,
// with the packed BCD result registered and updated only when a conversion ends.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int IN_WIDTH = 14,
  parameter int DIGITS   = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [IN_WIDTH-1:0]           bin,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;

  state_t              r_state;
  logic [IN_WIDTH-1:0] r_bin;
  logic [BCD_W-1:0]    r_scratch;
  logic                r_ovf;
  logic [CNT_W-1:0]    r_cnt;
  logic [BCD_W-1:0]    r_bcd;
  logic                r_overflow;
  logic                r_busy;
  logic                r_done;

  logic [BCD_W-1:0]    w_adj;
  logic [BCD_W-1:0]    w_next_scratch;
  logic                w_carry;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit (r_scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .o_digit (w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // A bit leaving the top digit means the value no longer fits in DIGITS digits;
  // what remains in the scratch register is the value modulo 10^DIGITS.
  assign w_next_scratch = {w_adj[BCD_W-2:0], r_bin[IN_WIDTH-1]};
  assign w_carry        = w_adj[BCD_W-1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_bin      <= '0;
      r_scratch  <= '0;
      r_ovf      <= 1'b0;
      r_cnt      <= '0;
      r_bcd      <= '0;
      r_overflow <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_bin     <= bin;
            r_scratch <= '0;
            r_ovf     <= 1'b0;
            r_cnt     <= CNT_W'(IN_WIDTH - 1);
            r_busy    <= 1'b1;
            r_state   <= SHIFT;
          end
        end
        SHIFT: begin
          r_bin     <= r_bin << 1;
          r_scratch <= w_next_scratch;
          r_ovf     <= r_ovf | w_carry;
          r_cnt     <= r_cnt - CNT_W'(1);
          if (r_cnt == '0) begin
            r_bcd      <= w_next_scratch;
            r_overflow <= r_ovf | w_carry;
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bcd      = r_bcd;
  assign busy     = r_busy;
  assign done     = r_done;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed cases from the test plan plus
// random conversions, compared against a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;

  localparam int IN_WIDTH = 14;
  localparam int DIGITS   = 4;
  localparam int LIMIT    = 10000;  // 10^DIGITS

  logic                  clk;
  logic                  reset_n;
  logic                  start;
  logic [IN_WIDTH-1:0]   bin;
  logic [4*DIGITS-1:0]   bcd;
  logic                  busy;
  logic                  done;
  logic                  overflow;

  int total;
  int bad;
  int done_cnt;
  logic [15:0] last_bcd;
  logic        last_ovf;

  bin_to_bcd_seq #(.IN_WIDTH(IN_WIDTH), .DIGITS(DIGITS)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .bin      (bin),
    .bcd      (bcd),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Reference: decimal digits of (v mod 10^DIGITS), computed with plain division.
  function automatic logic [15:0] ref_bcd(input int v);
    int r;
    r = v % LIMIT;
    return {4'(r / 1000), 4'((r / 100) % 10), 4'((r / 10) % 10), 4'(r % 10)};
  endfunction

  function automatic logic ref_ovf(input int v);
    return v >= LIMIT;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One conversion with a 1-cycle start; bin is scrambled right after capture.
  task automatic convert(input int v, input string tag);
    int cyc;
    @(negedge clk);
    start = 1'b1;
    bin   = IN_WIDTH'(v);
    @(negedge clk);
    start = 1'b0;
    bin   = IN_WIDTH'($urandom);
    check({tag, " busy_after_e0"}, 32'(busy), 32'd1);
    check({tag, " hold_old_bcd"}, 32'(bcd), 32'(last_bcd));
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'd14);
    check({tag, " bcd"}, 32'(bcd), 32'(ref_bcd(v)));
    check({tag, " overflow"}, 32'(overflow), 32'(ref_ovf(v)));
    check({tag, " busy_at_done"}, 32'(busy), 32'd0);
    last_bcd = ref_bcd(v);
    last_ovf = ref_ovf(v);
    @(negedge clk);
    check({tag, " done_pulse_width"}, 32'(done), 32'd0);
  endtask

  initial begin
    int cyc;
    int d0;
    int v;
    total    = 0;
    bad      = 0;
    done_cnt = 0;
    last_bcd = '0;
    last_ovf = 1'b0;
    reset_n  = 1'b0;
    start    = 1'b0;
    bin      = '0;

    repeat (3) @(negedge clk);
    check("reset bcd", 32'(bcd), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset overflow", 32'(overflow), 32'd0);
    reset_n = 1'b1;

    convert(1234, "d1234");
    convert(0, "d0");
    convert(9999, "d9999");
    convert(705, "d705");
    convert(16383, "d16383");
    convert(10000, "d10000");

    // start pulsed again at E5 while busy must be ignored
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    bin   = 14'd1234;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    bin   = 14'd42;
    @(negedge clk);
    start = 1'b0;
    cyc = 5;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("ignore latency", 32'(cyc), 32'd14);
    check("ignore bcd", 32'(bcd), 32'h1234);
    repeat (20) @(negedge clk);
    check("ignore done_count", 32'(done_cnt - d0), 32'd1);
    check("ignore idle", 32'(busy), 32'd0);
    last_bcd = 16'h1234;
    last_ovf = 1'b0;

    // reset sampled at E7 aborts the conversion and clears the result
    @(negedge clk);
    start = 1'b1;
    bin   = 14'd9999;
    @(negedge clk);
    start = 1'b0;
    d0 = done_cnt;
    repeat (6) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort bcd", 32'(bcd), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("abort no_done", 32'(done_cnt - d0), 32'd0);
    last_bcd = '0;
    last_ovf = 1'b0;
    convert(56, "after_abort");

    // start held high: back-to-back conversions every IN_WIDTH+1 cycles
    @(negedge clk);
    start = 1'b1;
    bin   = 14'd1;
    for (int k = 1; k <= 3; k++) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (done !== 1'b1 && cyc < 40);
      check($sformatf("b2b%0d period", k), 32'(cyc), 32'd15);
      check($sformatf("b2b%0d bcd", k), 32'(bcd), 32'(ref_bcd(k)));
      bin = IN_WIDTH'(k + 1);
    end
    start = 1'b0;
    repeat (16) @(negedge clk);
    last_bcd = ref_bcd(3);
    last_ovf = 1'b0;

    for (int n = 0; n < 12; n++) begin
      v = int'($urandom_range(16383, 0));
      convert(v, $sformatf("rand%0d_%0d", n, v));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
